// File: rtl/skolem_bvlshr_search.sv
// skolem_bvlshr_search
// Sequential Skolem-witness generator for logical-right-shift comparisons.
// For a latched request (s, t, mode) it scans shift amounts k = 0..W, one
// per cycle. It reports the smallest k with (s >> k) <u t (mode 0) or
// (s >> k) >u t (mode 1). If no k qualifies it reports found = 0.
// Optional feature macro: SKOLEM_IC_PRECHECK_EN. When it is defined, the
// accept cycle evaluates the closed-form invertibility condition. A request
// that fails that condition skips the scan.
module skolem_bvlshr_search #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         found,
    output logic [W-1:0] x_out
);

    // k must reach W itself, because every shift >= W behaves like a shift of W.
    localparam int KW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  s_q;
    logic [W-1:0]  t_q;
    logic          mode_q;
    logic [KW-1:0] k;
    logic [W-1:0]  shifted;
    logic          pred;
    logic          k_last;
    logic          ic_ok;

    // Predicate on the latched operands for the current candidate shift
    always_comb begin
        shifted = s_q >> k;
        pred    = mode_q ? (shifted > t_q) : (shifted < t_q);
        k_last  = (k == KW'(W));
`ifdef SKOLEM_IC_PRECHECK_EN
        ic_ok   = mode ? (s > t) : (t != '0);
`else
        ic_ok   = 1'b1;
`endif
    end

    // Next-state logic; a request that fails the precheck goes straight to DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ic_ok ? SEARCH : DONE;
            SEARCH:  if (pred || k_last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch, candidate counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            t_q    <= '0;
            mode_q <= 1'b0;
            k      <= '0;
            found  <= 1'b0;
            x_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_q    <= s;
                        t_q    <= t;
                        mode_q <= mode;
                        k      <= '0;
                        found  <= 1'b0;
                        x_out  <= '0;
                    end
                end
                SEARCH: begin
                    if (pred) begin
                        found <= 1'b1;
                        x_out <= W'(k);
                    end else if (k_last) begin
                        found <= 1'b0;
                        x_out <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags decode directly from the state register
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

endmodule

// File: tb/tb_skolem_bvlshr_search.sv
// tb_skolem_bvlshr_search
// Directed self-checking bench for skolem_bvlshr_search with W = 8.
// It uses hand-computed witnesses, latencies, backpressure and a mid-search reset.
// The no-witness latency depends on SKOLEM_IC_PRECHECK_EN.
module tb_skolem_bvlshr_search;

    localparam int W = 8;

    // Edges after the accepting edge until out_valid is seen for a no-witness request
`ifdef SKOLEM_IC_PRECHECK_EN
    localparam int NoWitnessEdges = 0;
`else
    localparam int NoWitnessEdges = W + 1;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic         found;
    logic [W-1:0] x_out;

    int checks = 0;
    int errors = 0;
    int edges;
    int spurious;

    skolem_bvlshr_search #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .t         (t),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .found     (found),
        .x_out     (x_out)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and on a difference count and report the failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present a request in IDLE, then scramble the inputs right after acceptance.
    // Count the edges until out_valid appears; the count is bounded.
    task automatic applyStimulus(input logic [W-1:0] sv, input logic [W-1:0] tv,
                                 input logic mv, output int nEdges);
        in_valid = 1'b1;
        s        = sv;
        t        = tv;
        mode     = mv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s        = '1;
        t        = ~tv;
        mode     = ~mv;
        nEdges   = 0;
        while (!out_valid && nEdges < 40) begin
            @(posedge clk);
            #1;
            nEdges++;
        end
    endtask

    // Accept the pending result and check that the block is back in IDLE
    task automatic releaseResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_ovalid_after"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_iready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = '0;
        t         = '0;
        mode      = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_found", 32'(found), 32'd0);
        checkOutput("rst_x_out", 32'(x_out), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // s=0x80, t=0x10, lt: 0x80>>4 = 0x08 < 0x10, so the witness is 4
        applyStimulus(8'h80, 8'h10, 1'b0, edges);
        checkOutput("lt_latency", 32'(edges), 32'd5);
        checkOutput("lt_found", 32'(found), 32'd1);
        checkOutput("lt_x", 32'(x_out), 32'd4);
        checkOutput("lt_in_ready", 32'(in_ready), 32'd0);
        releaseResult("lt");

        // s=0x80, t=0x10, gt: 0x80 > 0x10 already at shift 0
        applyStimulus(8'h80, 8'h10, 1'b1, edges);
        checkOutput("gt_latency", 32'(edges), 32'd1);
        checkOutput("gt_found", 32'(found), 32'd1);
        checkOutput("gt_x", 32'(x_out), 32'd0);
        releaseResult("gt");

        // t=0 in lt mode: no shifted value is below 0
        applyStimulus(8'h55, 8'h00, 1'b0, edges);
        checkOutput("t0_latency", 32'(edges), 32'(NoWitnessEdges));
        checkOutput("t0_found", 32'(found), 32'd0);
        checkOutput("t0_x", 32'(x_out), 32'd0);
        releaseResult("t0");

        // s=t=0x10 in gt mode: shifting never exceeds t; s is forced to 0xFF mid-search
        applyStimulus(8'h10, 8'h10, 1'b1, edges);
        checkOutput("eq_latency", 32'(edges), 32'(NoWitnessEdges));
        checkOutput("eq_found", 32'(found), 32'd0);
        checkOutput("eq_x", 32'(x_out), 32'd0);
        releaseResult("eq");

        // s=0x01, t=0x01, lt: 0x01>>1 = 0 < 1, so the witness is 1
        applyStimulus(8'h01, 8'h01, 1'b0, edges);
        checkOutput("one_latency", 32'(edges), 32'd2);
        checkOutput("one_found", 32'(found), 32'd1);
        checkOutput("one_x", 32'(x_out), 32'd1);
        releaseResult("one");

        // s=0xFF, t=0x01, lt: only shift 8 gives 0 < 1, the largest witness
        applyStimulus(8'hFF, 8'h01, 1'b0, edges);
        checkOutput("full_latency", 32'(edges), 32'd9);
        checkOutput("full_found", 32'(found), 32'd1);
        checkOutput("full_x", 32'(x_out), 32'd8);
        releaseResult("full");

        // Backpressure: the result must stay stable while out_ready is low
        applyStimulus(8'h80, 8'h10, 1'b0, edges);
        checkOutput("bp_latency", 32'(edges), 32'd5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_found_%0d", i), 32'(found), 32'd1);
            checkOutput($sformatf("bp_x_%0d", i), 32'(x_out), 32'd4);
            checkOutput($sformatf("bp_iready_%0d", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("bp_ovalid_%0d", i), 32'(out_valid), 32'd1);
        end
        releaseResult("bp");

        // Mid-search reset while k = 2; the aborted request must never produce a result
        in_valid = 1'b1;
        s        = 8'h80;
        t        = 8'h10;
        mode     = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_found", 32'(found), 32'd0);
        checkOutput("abort_x", 32'(x_out), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
        end
        checkOutput("abort_no_result", 32'(spurious), 32'd0);

        // A fresh request after the abort completes normally
        applyStimulus(8'h80, 8'h10, 1'b0, edges);
        checkOutput("post_latency", 32'(edges), 32'd5);
        checkOutput("post_found", 32'(found), 32'd1);
        checkOutput("post_x", 32'(x_out), 32'd4);
        releaseResult("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
